aq_axi_slave32_local: RTL and testbench
=======================================

Name: aq_axi_slave32_local

Overview:
- AXI4 32-bit slave (responder) that terminates the master-side bus and converts each burst beat into one single-word local-bus access.
- Serves one transaction at a time: write or read, never both.
- Sits between the interconnect and register banks / simple SRAMs in the same subsystem as the 32-bit single master.

Parameters:
ADDR_W, 32, local address width (LOCAL_ADDR = AWADDR/ARADDR[ADDR_W-1:0], byte address)
TIMEOUT_CYCLES, 255, local ACK timeout limit (only used when AQ_AXI_SLAVE_TIMEOUT_EN is defined)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWID  in  1  write ID
S_AXI_AWADDR  in  32  write address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WLAST  in  1  last beat
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BID  out  1  echoed AWID
S_AXI_BRESP  out  2  OKAY/SLVERR
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready
S_AXI_ARID  in  1  read ID
S_AXI_ARADDR  in  32  read address
S_AXI_ARLEN  in  8  beats-1
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RID  out  1  echoed ARID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  OKAY/SLVERR
S_AXI_RLAST  out  1  last beat
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready
LOCAL_CS  out  1  access request, held until ACK
LOCAL_RNW  out  1  1=read, 0=write
LOCAL_ADDR  out  ADDR_W  word-aligned byte address
LOCAL_BE  out  4  byte enables (writes), 4'hF (reads)
LOCAL_WDATA  out  32  write data
LOCAL_RDATA  in  32  read data, valid with ACK
LOCAL_ACK  in  1  access complete; may assert in the first CS cycle

Behaviour:
- Reset: all outputs 0; state IDLE; priority flag = write.
- Bursts are treated as INCR only; size is fixed at 4 bytes.
- Address: [1:0] forced to 0; +4 per beat; bits [31:12] held, so the address wraps within the 4 KB page.
- FSM states: IDLE, W_DATA, W_LOCAL, W_RESP, R_LOCAL, R_DATA.
- IDLE arbitration:
  - Only AWVALID: pulse AWREADY for 1 cycle; latch ID, ADDR and LEN; clear the error flag; go to W_DATA.
  - Only ARVALID: pulse ARREADY for 1 cycle; latch likewise; go to R_LOCAL.
  - Both valid: serve the side given by the priority flag; the flag toggles after every granted transaction.
- W_DATA: WREADY=1.
  - On WVALID, register data/strobe and deassert WREADY.
  - WSTRB≠0: go to W_LOCAL.
  - WSTRB=0: no local access; advance the beat directly.
- W_LOCAL: CS=1, RNW=0. On ACK, drop CS the next cycle.
  - Beats remaining: go to W_DATA.
  - Last beat: go to W_RESP.
- WLAST checking: WLAST on a non-final beat, or missing on the final beat, sets SLVERR. The burst always consumes exactly AWLEN+1 beats.
- W_RESP: BVALID=1, BRESP = {err,1'b0}. On BREADY, go to IDLE.
- R_LOCAL: CS=1, RNW=1, BE=4'hF. On ACK, capture LOCAL_RDATA and go to R_DATA.
- R_DATA: RVALID=1; RDATA/RRESP/RLAST are stable while RVALID && !RREADY. RLAST is set on beat ARLEN. On RREADY:
  - Beats remaining: go to R_LOCAL.
  - Last beat: go to IDLE.
- Throughput:
  - Best write beat: 2 cycles (ACK in the first CS cycle).
  - Best read beat: 2 cycles.
  - AR accept to first RVALID: 2 cycles.
- Reset mid-burst: immediate return to IDLE; CS drops; no response is issued.
- ARLEN/AWLEN=0: single beat; RLAST is set on the first beat.

Optional Feature:
- Macro: AQ_AXI_SLAVE_TIMEOUT_EN.
- Defined:
  - A counter runs while CS=1 without ACK.
  - At TIMEOUT_CYCLES the access is aborted: CS drops, the beat completes with SLVERR, and read data is 32'hDEADBEEF.
  - A write error is sticky into BRESP; read errors are per-beat RRESP.
- Undefined: CS is held indefinitely until ACK; no counter logic is present.

Decomposition:
- Package aq_axi_slave_pkg: state encodings, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, timeout data constant.
- Sub-module aq_axi_slave_addr_gen: 4 KB-wrapping incrementer plus beat counter with last flag, instantiated once and loaded on AW or AR grant.

Test Plan:
- Write AWADDR=0x100, AWLEN=3, data 1..4, WSTRB=F, ACK same cycle -> local writes to 0x100/104/108/10C; BRESP=OKAY; BID echoes AWID.
- Read ARADDR=0x200, ARLEN=1, RREADY low 3 cycles on beat 0 -> RDATA held stable; RLAST only on beat 1; RRESP=OKAY.
- AWVALID and ARVALID asserted together, twice -> write granted first, read second; priority alternates on each subsequent collision.
- AWLEN=1 with WLAST on beat 0 -> 2 local writes; BRESP=SLVERR. WSTRB=0 on a beat -> no CS pulse for that beat.
- Burst at 0xFFC, LEN=1 -> second beat address 0x000 (page 0x0000_0xxx kept); ARESETN dropped mid-burst -> all outputs 0 next edge.
- With AQ_AXI_SLAVE_TIMEOUT_EN defined, ACK never asserted -> after 255 CS cycles, RRESP=SLVERR, RDATA=0xDEADBEEF.

Source files
------------

// File: rtl/aq_axi_slave_pkg.sv
// Shared types and constants for the AXI4 32-bit slave to local-bus bridge.
package aq_axi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_DATA,
    ST_W_LOCAL,
    ST_W_RESP,
    ST_R_LOCAL,
    ST_R_DATA
  } state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Next word address; bits [31:12] never change, so bursts wrap inside the 4 KB page.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return {addr[31:12], addr[11:2] + 10'd1, 2'b00};
  endfunction

endpackage

// File: rtl/aq_axi_slave_addr_gen.sv
// Beat address generator: word-aligned, 4 KB-wrapping incrementer plus beat counter.
module aq_axi_slave_addr_gen
  import aq_axi_slave_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic [7:0]  load_len,
  input  logic        advance,
  output logic [31:0] addr,
  output logic        last
);

  logic [7:0] beat_cnt;
  logic [7:0] beat_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      beat_cnt <= '0;
      beat_len <= '0;
    end else if (load) begin
      addr     <= load_addr & 32'hFFFF_FFFC;
      beat_cnt <= '0;
      beat_len <= load_len;
    end else if (advance) begin
      addr     <= next_word_addr(addr);
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  assign last = (beat_cnt == beat_len);

endmodule

// File: rtl/aq_axi_slave32_local.sv
// AXI4 32-bit slave that turns each burst beat into one single-word local-bus access.
// Optional local ACK timeout is enabled by defining AQ_AXI_SLAVE_TIMEOUT_EN.
module aq_axi_slave32_local
  import aq_axi_slave_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              S_AXI_AWID,
  input  logic [31:0]       S_AXI_AWADDR,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic              S_AXI_BID,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic              S_AXI_ARID,
  input  logic [31:0]       S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic              S_AXI_RID,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              LOCAL_CS,
  output logic              LOCAL_RNW,
  output logic [ADDR_W-1:0] LOCAL_ADDR,
  output logic [3:0]        LOCAL_BE,
  output logic [31:0]       LOCAL_WDATA,
  input  logic [31:0]       LOCAL_RDATA,
  input  logic              LOCAL_ACK
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, state_next;
  logic        run;
  logic        prio_w;
  logic        id_r;
  logic        err;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;

  logic        aw_grant, ar_grant;
  logic        load, advance;
  logic        cs;
  logic        local_done, local_err;
  logic [31:0] addr;
  logic        last;

  // run keeps the ready pulses low while ARESETN is held, even if a master drives VALID.
  assign aw_grant = (state == ST_IDLE) && run && S_AXI_AWVALID && (!S_AXI_ARVALID || prio_w);
  assign ar_grant = (state == ST_IDLE) && run && S_AXI_ARVALID && (!S_AXI_AWVALID || !prio_w);
  assign cs       = (state == ST_W_LOCAL) || (state == ST_R_LOCAL);

`ifdef AQ_AXI_SLAVE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  assign timeout = cs && !LOCAL_ACK && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                       to_cnt <= '0;
    else if (cs && !LOCAL_ACK && !timeout) to_cnt <= to_cnt + 1'b1;
    else                                to_cnt <= '0;
  end

  assign local_done = LOCAL_ACK || timeout;
  assign local_err  = timeout;
`else
  assign local_done = LOCAL_ACK;
  assign local_err  = 1'b0;
`endif

  aq_axi_slave_addr_gen u_addr_gen (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .load      (load),
    .load_addr (aw_grant ? S_AXI_AWADDR : S_AXI_ARADDR),
    .load_len  (aw_grant ? S_AXI_AWLEN  : S_AXI_ARLEN),
    .advance   (advance),
    .addr      (addr),
    .last      (last)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    load          = 1'b0;
    advance       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (aw_grant) begin
          S_AXI_AWREADY = 1'b1;
          load          = 1'b1;
          state_next    = ST_W_DATA;
        end else if (ar_grant) begin
          S_AXI_ARREADY = 1'b1;
          load          = 1'b1;
          state_next    = ST_R_LOCAL;
        end
      end
      ST_W_DATA: begin
        S_AXI_WREADY = 1'b1;
        // An all-zero strobe beat skips the local access but still consumes a beat.
        if (S_AXI_WVALID) begin
          if (S_AXI_WSTRB != 4'h0) state_next = ST_W_LOCAL;
          else if (last)           state_next = ST_W_RESP;
          else                     advance    = 1'b1;
        end
      end
      ST_W_LOCAL: begin
        if (local_done) begin
          if (last) begin
            state_next = ST_W_RESP;
          end else begin
            advance    = 1'b1;
            state_next = ST_W_DATA;
          end
        end
      end
      ST_W_RESP: begin
        if (S_AXI_BREADY) state_next = ST_IDLE;
      end
      ST_R_LOCAL: begin
        if (local_done) state_next = ST_R_DATA;
      end
      ST_R_DATA: begin
        if (S_AXI_RREADY) begin
          if (last) begin
            state_next = ST_IDLE;
          end else begin
            advance    = 1'b1;
            state_next = ST_R_LOCAL;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      run     <= 1'b0;
      prio_w  <= 1'b1;
      id_r    <= 1'b0;
      err     <= 1'b0;
      wdata_r <= '0;
      wstrb_r <= '0;
      rdata_r <= '0;
      rresp_r <= RESP_OKAY;
    end else begin
      run <= 1'b1;
      if (aw_grant) begin
        id_r   <= S_AXI_AWID;
        err    <= 1'b0;
        prio_w <= !prio_w;
      end else if (ar_grant) begin
        id_r   <= S_AXI_ARID;
        prio_w <= !prio_w;
      end
      if ((state == ST_W_DATA) && S_AXI_WVALID) begin
        wdata_r <= S_AXI_WDATA;
        wstrb_r <= S_AXI_WSTRB;
        if (S_AXI_WLAST != last) err <= 1'b1;
      end
      if ((state == ST_W_LOCAL) && local_done && local_err) err <= 1'b1;
      if ((state == ST_R_LOCAL) && local_done) begin
        rdata_r <= local_err ? TIMEOUT_DATA : LOCAL_RDATA;
        rresp_r <= local_err ? RESP_SLVERR  : RESP_OKAY;
      end
    end
  end

  assign S_AXI_BID    = id_r;
  assign S_AXI_BVALID = (state == ST_W_RESP);
  assign S_AXI_BRESP  = ((state == ST_W_RESP) && err) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RID    = id_r;
  assign S_AXI_RDATA  = rdata_r;
  assign S_AXI_RRESP  = rresp_r;
  assign S_AXI_RVALID = (state == ST_R_DATA);
  assign S_AXI_RLAST  = (state == ST_R_DATA) && last;

  assign LOCAL_CS    = cs;
  assign LOCAL_RNW   = (state == ST_R_LOCAL);
  assign LOCAL_ADDR  = addr[ADDR_W-1:0];
  assign LOCAL_BE    = (state == ST_R_LOCAL) ? 4'hF : ((state == ST_W_LOCAL) ? wstrb_r : 4'h0);
  assign LOCAL_WDATA = wdata_r;

endmodule

// File: tb/tb_aq_axi_slave32_local.sv
// Directed self-checking bench for aq_axi_slave32_local (local bus modelled with a combinational responder).
module tb_aq_axi_slave32_local;

  logic        ACLK, ARESETN;
  logic        S_AXI_AWID, S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic        S_AXI_BID, S_AXI_BVALID, S_AXI_BREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARID, S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic        S_AXI_RID, S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        LOCAL_CS, LOCAL_RNW, LOCAL_ACK;
  logic [31:0] LOCAL_ADDR, LOCAL_WDATA, LOCAL_RDATA;
  logic [3:0]  LOCAL_BE;

  logic ack_en;
  int   checks = 0;
  int   failures = 0;
  int   cs_cycles = 0;
  int   wait_lim = 50;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        rnw;
  } acc_t;
  acc_t log_q[$];

  aq_axi_slave32_local #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .LOCAL_CS(LOCAL_CS), .LOCAL_RNW(LOCAL_RNW), .LOCAL_ADDR(LOCAL_ADDR), .LOCAL_BE(LOCAL_BE),
    .LOCAL_WDATA(LOCAL_WDATA), .LOCAL_RDATA(LOCAL_RDATA), .LOCAL_ACK(LOCAL_ACK)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Read data encodes the low address half so every beat's expected data is obvious.
  assign LOCAL_ACK   = ack_en & LOCAL_CS;
  assign LOCAL_RDATA = {16'hA5A5, LOCAL_ADDR[15:0]};

  always @(posedge ACLK) begin
    if (LOCAL_CS) cs_cycles++;
    if (LOCAL_CS && LOCAL_ACK) log_q.push_back('{LOCAL_ADDR, LOCAL_WDATA, LOCAL_BE, LOCAL_RNW});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_outs();
    return 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
                S_AXI_ARREADY, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
                LOCAL_CS, LOCAL_RNW, LOCAL_BE});
  endfunction

  task automatic check_acc(input string tag, input int idx, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, input logic rnw);
    if (idx >= log_q.size()) begin
      check({tag, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      check({tag, "_addr"}, log_q[idx].addr, addr);
      if (!rnw) check({tag, "_data"}, log_q[idx].data, data);
      check({tag, "_be"}, 32'(log_q[idx].be), 32'(be));
      check({tag, "_rnw"}, 32'(log_q[idx].rnw), 32'(rnw));
    end
  endtask

  // All handshake tasks start and end just after a falling edge.
  task automatic aw_send(input logic id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWVALID = 1'b1;
    #1;
    while (!S_AXI_AWREADY && n < wait_lim) begin @(negedge ACLK); #1; n++; end
    check("aw_ready", 32'(S_AXI_AWREADY), 32'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARVALID = 1'b1;
    #1;
    while (!S_AXI_ARREADY && n < wait_lim) begin @(negedge ACLK); #1; n++; end
    check("ar_ready", 32'(S_AXI_ARREADY), 32'd1);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic wlast);
    int n = 0;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WLAST = wlast; S_AXI_WVALID = 1'b1;
    #1;
    while (!S_AXI_WREADY && n < wait_lim) begin @(negedge ACLK); #1; n++; end
    check("w_ready", 32'(S_AXI_WREADY), 32'd1);
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic b_recv(input logic id, input logic [1:0] resp);
    int n = 0;
    S_AXI_BREADY = 1'b1;
    #1;
    while (!S_AXI_BVALID && n < wait_lim) begin @(negedge ACLK); #1; n++; end
    check("b_valid", 32'(S_AXI_BVALID), 32'd1);
    check("b_id", 32'(S_AXI_BID), 32'(id));
    check("b_resp", 32'(S_AXI_BRESP), 32'(resp));
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic r_wait();
    int n = 0;
    #1;
    while (!S_AXI_RVALID && n < wait_lim) begin @(negedge ACLK); #1; n++; end
    check("r_valid", 32'(S_AXI_RVALID), 32'd1);
  endtask

  task automatic r_recv(input logic [31:0] data, input logic [1:0] resp, input logic rlast,
                        input logic id);
    S_AXI_RREADY = 1'b1;
    r_wait();
    check("r_data", S_AXI_RDATA, data);
    check("r_resp", 32'(S_AXI_RRESP), 32'(resp));
    check("r_last", 32'(S_AXI_RLAST), 32'(rlast));
    check("r_id", 32'(S_AXI_RID), 32'(id));
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    ARESETN = 1'b0; ack_en = 1'b1;
    S_AXI_AWID = 0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARID = 0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;

    repeat (2) @(negedge ACLK);
    #1;
    check("rst_ctrl", ctrl_outs(), 32'd0);
    check("rst_addr", LOCAL_ADDR, 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("idle_ctrl", ctrl_outs(), 32'd0);

    // 4-beat write burst
    base = log_q.size();
    aw_send(1'b1, 32'h100, 8'd3);
    for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
    b_recv(1'b1, 2'b00);
    check("wr4_count", 32'(log_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check_acc($sformatf("wr4_%0d", i), base + i, 32'h100 + 32'(4 * i), 32'(i + 1), 4'hF, 1'b0);

    // 2-beat read with back-pressure on beat 0
    base = log_q.size();
    ar_send(1'b0, 32'h200, 8'd1);
    r_wait();
    for (int i = 0; i < 3; i++) begin
      check("rd_hold_valid", 32'(S_AXI_RVALID), 32'd1);
      check("rd_hold_data", S_AXI_RDATA, 32'hA5A5_0200);
      check("rd_hold_last", 32'(S_AXI_RLAST), 32'd0);
      @(negedge ACLK);
      #1;
    end
    r_recv(32'hA5A5_0200, 2'b00, 1'b0, 1'b0);
    r_recv(32'hA5A5_0204, 2'b00, 1'b1, 1'b0);
    check("rd2_count", 32'(log_q.size() - base), 32'd2);
    check_acc("rd2_1", base + 1, 32'h204, 32'h0, 4'hF, 1'b1);

    // Collision with write priority: write first, read afterwards
    S_AXI_AWID = 0; S_AXI_AWADDR = 32'h300; S_AXI_AWLEN = 0; S_AXI_AWVALID = 1;
    S_AXI_ARID = 1; S_AXI_ARADDR = 32'h400; S_AXI_ARLEN = 0; S_AXI_ARVALID = 1;
    #1;
    check("colA_awready", 32'(S_AXI_AWREADY), 32'd1);
    check("colA_arready", 32'(S_AXI_ARREADY), 32'd0);
    @(negedge ACLK);
    S_AXI_AWVALID = 0;
    w_send(32'h1111_1111, 4'hF, 1'b1);
    b_recv(1'b0, 2'b00);
    ar_send(1'b1, 32'h400, 8'd0);
    r_recv(32'hA5A5_0400, 2'b00, 1'b1, 1'b1);

    // WLAST on non-final beat: both beats still written, SLVERR returned
    base = log_q.size();
    aw_send(1'b1, 32'h500, 8'd1);
    w_send(32'hAAAA_0001, 4'hF, 1'b1);
    w_send(32'hAAAA_0002, 4'hF, 1'b1);
    b_recv(1'b1, 2'b10);
    check("wlast_count", 32'(log_q.size() - base), 32'd2);
    check_acc("wlast_1", base + 1, 32'h504, 32'hAAAA_0002, 4'hF, 1'b0);

    // Collision after a lone write: read now has priority; error flag cleared on next write
    S_AXI_AWID = 0; S_AXI_AWADDR = 32'h600; S_AXI_AWLEN = 0; S_AXI_AWVALID = 1;
    S_AXI_ARID = 0; S_AXI_ARADDR = 32'h700; S_AXI_ARLEN = 0; S_AXI_ARVALID = 1;
    #1;
    check("colB_arready", 32'(S_AXI_ARREADY), 32'd1);
    check("colB_awready", 32'(S_AXI_AWREADY), 32'd0);
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    r_recv(32'hA5A5_0700, 2'b00, 1'b1, 1'b0);
    aw_send(1'b0, 32'h600, 8'd0);
    w_send(32'h2222_2222, 4'hF, 1'b1);
    b_recv(1'b0, 2'b00);

    // Zero-strobe beat produces no local access
    base = log_q.size();
    cs_cycles = cs_cycles;
    aw_send(1'b0, 32'h800, 8'd2);
    w_send(32'hC0, 4'hF, 1'b0);
    w_send(32'hC1, 4'h0, 1'b0);
    w_send(32'hC2, 4'h3, 1'b1);
    b_recv(1'b0, 2'b00);
    check("strb0_count", 32'(log_q.size() - base), 32'd2);
    check_acc("strb0_0", base, 32'h800, 32'hC0, 4'hF, 1'b0);
    check_acc("strb0_1", base + 1, 32'h808, 32'hC2, 4'h3, 1'b0);

    // 4 KB page wrap: upper address bits held
    base = log_q.size();
    ar_send(1'b0, 32'h1234_5FFC, 8'd1);
    r_recv(32'hA5A5_5FFC, 2'b00, 1'b0, 1'b0);
    r_recv(32'hA5A5_5000, 2'b00, 1'b1, 1'b0);
    check_acc("wrap_0", base, 32'h1234_5FFC, 32'h0, 4'hF, 1'b1);
    check_acc("wrap_1", base + 1, 32'h1234_5000, 32'h0, 4'hF, 1'b1);

    // Reset mid-burst while a local write waits for ACK
    ack_en = 1'b0;
    base = log_q.size();
    aw_send(1'b0, 32'h900, 8'd3);
    w_send(32'h9, 4'hF, 1'b0);
    #1;
    check("mid_cs", 32'(LOCAL_CS), 32'd1);
    check("mid_addr", LOCAL_ADDR, 32'h900);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_ctrl", ctrl_outs(), 32'd0);
    check("mid_rst_addr", LOCAL_ADDR, 32'd0);
    check("mid_rst_wdata", LOCAL_WDATA, 32'd0);
    check("mid_rst_rdata", S_AXI_RDATA, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge ACLK);
    check("post_rst_ctrl", ctrl_outs(), 32'd0);
    check("post_rst_count", 32'(log_q.size() - base), 32'd0);
    ar_send(1'b1, 32'hB00, 8'd0);
    r_recv(32'hA5A5_0B00, 2'b00, 1'b1, 1'b1);

`ifdef AQ_AXI_SLAVE_TIMEOUT_EN
    begin
      int cs0;
      ack_en = 1'b0;
      wait_lim = 400;
      cs0 = cs_cycles;
      ar_send(1'b0, 32'hA00, 8'd0);
      r_recv(32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0);
      check("to_cs_cycles", 32'(cs_cycles - cs0), 32'd255);
      ack_en = 1'b1;
      wait_lim = 50;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
